// File: rtl/data_memory_responder.sv
// Wait-state data memory for the MEM stage: latches one request, performs it
// after WAIT_CYCLES cycles and holds ready low (pipeline freeze) until then.
module data_memory_responder #(
  parameter int N           = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,  // word aligned
  parameter int WAIT_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MEM_R_EN,
  input  logic         MEM_W_EN,
  input  logic [N-1:0] ALU_Res,
  input  logic [N-1:0] Val_Rm,
  output logic [N-1:0] rdata,
  output logic         ready,
  output logic         addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [N-1:0]  BASE     = N'(BASE_ADDR);
  localparam logic [N-3:0]  BASE_W   = BASE[N-1:2];
  localparam logic [N-3:0]  DEPTH_W  = (N-2)'(DEPTH);
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_w, lat_r;
  logic [N-1:0]  lat_addr, lat_data;
  logic [N-1:0]  mem [DEPTH];

  logic          start, fire, illegal;
  logic          acc_w, acc_r;
  logic [N-1:0]  acc_addr, acc_data;
  logic [N-3:0]  word;
  logic [AW-1:0] idx;

  assign ready = (state == IDLE && !MEM_R_EN && !MEM_W_EN) || state == DONE;

  // With no wait states the access happens at the accepting edge, so it must
  // use the live request rather than the latched copy.
  always_comb begin
    start    = (state == IDLE) && (MEM_R_EN || MEM_W_EN);
    acc_w    = ZERO_WAIT ? MEM_W_EN              : lat_w;
    acc_r    = ZERO_WAIT ? (MEM_R_EN & ~MEM_W_EN) : lat_r;
    acc_addr = ZERO_WAIT ? ALU_Res               : lat_addr;
    acc_data = ZERO_WAIT ? Val_Rm                : lat_data;
    fire     = ZERO_WAIT ? start : (state == BUSY && cnt == '0);
    word     = acc_addr[N-1:2] - BASE_W;
    illegal  = (acc_addr < BASE) || (acc_addr[1:0] != 2'b00) || (word >= DEPTH_W);
    idx      = word[AW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_w    <= 1'b0;
      lat_r    <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      rdata    <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= fire && illegal;
      if (fire && acc_r)
        rdata <= illegal ? '0 : mem[idx];
      case (state)
        IDLE: if (start) begin
          lat_w    <= MEM_W_EN;
          lat_r    <= MEM_R_EN & ~MEM_W_EN;
          lat_addr <= ALU_Res;
          lat_data <= Val_Rm;
          if (ZERO_WAIT) begin
            state <= DONE;
          end else begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array is built from resettable flops because reset must clear
  // every word; a RAM macro could not honour that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fire && acc_w && !illegal) begin
      mem[idx] <= acc_data;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: one responder with 3 wait states and one with none,
// checking handshake timing, data, illegal addresses and reset behaviour.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        r3, w3, r0, w0;
  logic [31:0] a3, d3, a0, d0;
  logic [31:0] rdata3, rdata0;
  logic        ready3, ready0, err3, err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.N(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .MEM_R_EN(r3), .MEM_W_EN(w3), .ALU_Res(a3), .Val_Rm(d3),
    .rdata(rdata3), .ready(ready3), .addr_err(err3)
  );

  data_memory_responder #(.N(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r0), .MEM_W_EN(w0), .ALU_Res(a0), .Val_Rm(d0),
    .rdata(rdata0), .ready(ready0), .addr_err(err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit z, input bit r, input bit w,
                       input logic [31:0] addr, input logic [31:0] data);
    if (z) begin r0 = r; w0 = w; a0 = addr; d0 = data; end
    else   begin r3 = r; w3 = w; a3 = addr; d3 = data; end
  endtask

  // One complete access; inputs are applied at the falling edge and held
  // until the DONE cycle. scramble alters the inputs during the wait states.
  task automatic access(input bit z, input bit r, input bit w,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rdata, input bit exp_err,
                        input bit scramble);
    int waits = z ? 0 : 3;
    @(negedge clk);
    drive(z, r, w, addr, data);
    #1 check("ready_low_req", z ? ready0 : ready3, 0);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (scramble) drive(z, 1'b1, 1'b0, addr + 32'd4, ~data);
      #1 check("ready_low_busy", z ? ready0 : ready3, 0);
    end
    @(negedge clk);
    drive(z, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("ready_done", z ? ready0 : ready3, 1);
    check("addr_err_done", z ? err0 : err3, {31'd0, exp_err});
    check("rdata_done", z ? rdata0 : rdata3, exp_rdata);
  endtask

  task automatic idle(input bit z, input int n, input logic [31:0] exp_rdata);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check("ready_idle", z ? ready0 : ready3, 1);
      check("addr_err_idle", z ? err0 : err3, 0);
      check("rdata_idle", z ? rdata0 : rdata3, exp_rdata);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset held for two cycles, then idle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("rst_ready", ready3, 1);
      check("rst_rdata", rdata3, 0);
      check("rst_addr_err", err3, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0, 3, 32'd0);

    // Write then read back.
    access(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    idle(1'b0, 1, 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Illegal addresses, last legal word, then word 0 intact.
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'd1020, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(1'b0, 1, 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'd1026, 32'd0, 32'd0, 1'b1, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'd1280, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(1'b0, 1, 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'd1276, 32'd0, 32'd0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 1'b0, 1'b0);

    // Read+write together acts as a write; inputs changed while busy are ignored.
    access(1'b0, 1'b1, 1'b1, 32'd1024, 32'h5, 32'h12345678, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'h5, 1'b0, 1'b0);
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h11111111, 32'h5, 1'b0, 1'b1);
    access(1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 32'h11111111, 1'b0, 1'b0);

    // Reset in the middle of a write.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'd1028, 32'h22222222);
    #1 check("mid_ready_req", ready3, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready_req", ready3, 0);
    check("mid_rst_rdata", rdata3, 0);
    check("mid_rst_addr_err", err3, 0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 check("mid_rst_ready_idle", ready3, 1);
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0, 1, 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 32'd0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 32'd0, 1'b0, 1'b0);

    // Zero-wait instance: fill three words, then three back-to-back reads.
    idle(1'b1, 1, 32'd0);
    access(1'b1, 1'b0, 1'b1, 32'd1024, 32'hAAAA0001, 32'd0, 1'b0, 1'b0);
    access(1'b1, 1'b0, 1'b1, 32'd1028, 32'hBBBB0002, 32'd0, 1'b0, 1'b0);
    access(1'b1, 1'b0, 1'b1, 32'd1032, 32'hCCCC0003, 32'd0, 1'b0, 1'b0);
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hAAAA0001, 1'b0, 1'b0);
    access(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 32'hBBBB0002, 1'b0, 1'b0);
    access(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 32'hCCCC0003, 1'b0, 1'b0);
    idle(1'b1, 1, 32'hCCCC0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Memory-side responder for the MEM-stage data-memory interface. It accepts the read or write request that the MEM stage issues, translates the byte address into a word index, and performs the access after a configurable number of wait states. While the access is in progress it drives ready low, and the pipeline uses ~ready as its freeze signal. It replaces the zero-latency data memory so that the hazard and freeze paths can be exercised with realistic memory timing.

Parameters:
N, 32, data and address width
DEPTH, 64, number of N-bit words stored
BASE_ADDR, 1024, byte address that maps to word 0
WAIT_CYCLES, 3, wait states per access (0 allowed)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
MEM_R_EN  input  1  read request from the MEM stage
MEM_W_EN  input  1  write request from the MEM stage
ALU_Res  input  N  byte address of the access
Val_Rm  input  N  store data
rdata  output  N  read data, registered
ready  output  1  access complete or idle; low means freeze the pipeline
addr_err  output  1  one-cycle pulse flagging an illegal address

Behaviour:
- Reset is asynchronous and active-low: rst=0 immediately forces the following, regardless of clk.
  - state=IDLE, wait counter=0, rdata=0, addr_err=0.
  - All DEPTH words cleared to 0.
  - Any pending write is discarded.
- ready is combinational: ready = (state==IDLE && !MEM_R_EN && !MEM_W_EN) || state==DONE. During reset, ready=1 (no request) or 0 (a request is present).
- FSM with three states: IDLE, BUSY, DONE.
  - IDLE: when MEM_R_EN or MEM_W_EN is high at a rising edge, latch op, ALU_Res and Val_Rm. Next state is BUSY with counter=WAIT_CYCLES-1, or DONE directly if WAIT_CYCLES==0.
  - BUSY: counter decrements each edge. At the edge where counter==0, next state is DONE and the access is performed at that same edge:
    - write: mem[idx] <= latched data;
    - read: rdata <= mem[idx].
  - DONE: lasts exactly one cycle. ready=1, so the pipeline advances at this edge. Next state is IDLE.
- Request inputs are ignored in BUSY and DONE; only the latched copy is used.
- Latency: a request first seen in cycle T holds ready low for cycles T..T+WAIT_CYCLES (WAIT_CYCLES+1 cycles in total). DONE is cycle T+WAIT_CYCLES+1; rdata is valid from that cycle on.
- With WAIT_CYCLES=0 the sequence is IDLE (ready low 1 cycle) -> DONE -> IDLE.
- Address translation: idx = (ALU_Res - BASE_ADDR) >> 2, using the low clog2(DEPTH) bits.
- The address is illegal when ALU_Res < BASE_ADDR, ALU_Res[1:0] != 0, or (ALU_Res - BASE_ADDR) >> 2 >= DEPTH. For an illegal address:
  - no write occurs, and rdata is set to 0;
  - addr_err=1 during the DONE cycle only; the handshake timing is unchanged.
- MEM_R_EN and MEM_W_EN both high: treated as a write only, and rdata is unchanged.
- rdata holds the last read result until the next read completes. Writes never change rdata.
- Back-to-back requests: a request present in the IDLE cycle immediately after DONE starts a new access. No idle bubble is required beyond the IDLE cycle itself.
- Counter width: max(1, clog2(WAIT_CYCLES+1)). The counter does not wrap in normal use.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, release, no requests -> ready=1, rdata=0, addr_err=0 on every cycle.
2. Write then read, WAIT_CYCLES=3:
   - write 0xDEADBEEF to address 1032 -> ready low for exactly 4 cycles, then high for 1 cycle;
   - read from 1032 -> ready low 4 cycles, and rdata=0xDEADBEEF in the DONE cycle.
3. Illegal addresses: reads from 1020, 1026 and 1024+4*64 -> each gives addr_err=1 for one cycle in DONE and rdata=0; a subsequent read of word 0 returns its previous contents unchanged.
4. Simultaneous requests: MEM_R_EN=MEM_W_EN=1 with address 1024 and data 0x5 -> word 0 becomes 5 and rdata keeps its prior value. Also, with request inputs changed during BUSY, the latched address is still the one used.
5. Reset mid-access: assert rst=0 during a BUSY write to 1028 -> state immediately IDLE, word 1 reads back 0 after reset, and rdata=0.
6. WAIT_CYCLES=0 build: three back-to-back reads -> each shows ready low for 1 cycle, and the correct data appears in the following cycle.
